// File: rtl/biquad_tap_sequencer.sv
// biquad_tap_sequencer
//   Read-side controller and multiply-accumulate for one biquad section.
//   Each accepted sample is pushed into the x delay line. The five taps are
//   then read back in order and y[n] is accumulated:
//     y[n] = b0*x[n] + b1*x[n-1] + b2*x[n-2] - a1*y[n-1] - a2*y[n-2]
//   The result is rounded, saturated, written into the y delay line and held
//   on a valid/ready output.
//
// Ports
//   clk, reset            clock, asynchronous active-low reset
//   in_valid/in_ready     sample handshake, in_data = x[n]
//   coef_b0..coef_a2      signed coefficients, captured on accept
//   mem_x_enable, mem_x   x delay-line shift strobe / data
//   mem_y_enable, mem_y   y delay-line shift strobe / data
//   mem_dir               tap select 0..4 (x[n],x[n-1],x[n-2],y[n-1],y[n-2])
//   mem_out               tap data, returned one cycle after mem_dir
//   out_valid/out_ready   result handshake, out_data = y[n]
//   busy                  high whenever the sequencer is not idle
//   out_sat               (only with BIQUAD_TAP_SEQUENCER_SAT_FLAG_EN)
//                         set when y[n] was clipped
module biquad_tap_sequencer #(
  parameter int COEF_W    = 18,
  parameter int FRAC_BITS = 14,
  parameter int ACC_W     = COEF_W + 35
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [31:0]       in_data,
  input  logic signed [COEF_W-1:0] coef_b0,
  input  logic signed [COEF_W-1:0] coef_b1,
  input  logic signed [COEF_W-1:0] coef_b2,
  input  logic signed [COEF_W-1:0] coef_a1,
  input  logic signed [COEF_W-1:0] coef_a2,
  output logic                     mem_x_enable,
  output logic [31:0]              mem_x,
  output logic                     mem_y_enable,
  output logic [31:0]              mem_y,
  output logic [2:0]               mem_dir,
  input  logic signed [31:0]       mem_out,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [31:0]       out_data,
  output logic                     busy
`ifdef BIQUAD_TAP_SEQUENCER_SAT_FLAG_EN
  ,
  output logic                     out_sat
`endif
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ISSUE = 3'd1;
  localparam logic [2:0] S_DRAIN = 3'd2;
  localparam logic [2:0] S_WRITE = 3'd3;
  localparam logic [2:0] S_HOLD  = 3'd4;

  localparam int PROD_W = 32 + COEF_W;

  localparam logic signed [ACC_W-1:0] RND    = ACC_W'(1) << (FRAC_BITS - 1);
  localparam logic signed [ACC_W-1:0] SAT_HI = ACC_W'(32'h7FFF_FFFF);
  // bitwise complement of 2^31-1 is -2^31
  localparam logic signed [ACC_W-1:0] SAT_LO = ~SAT_HI;

  logic [2:0]               r_state;
  logic [2:0]               r_tap;
  logic signed [ACC_W-1:0]  r_acc;
  logic signed [COEF_W-1:0] r_b0, r_b1, r_b2, r_a1, r_a2;
  logic signed [31:0]       r_out_data;

  logic                     w_accept;
  logic                     w_mac_en;
  logic [2:0]               w_mac_sel;
  logic signed [COEF_W-1:0] w_coef;
  logic                     w_sub;
  logic signed [PROD_W-1:0] w_prod;
  logic signed [ACC_W-1:0]  w_prod_ext;
  logic signed [ACC_W-1:0]  w_round;
  logic signed [ACC_W-1:0]  w_shift;
  logic signed [31:0]       w_y;

  // Gating with reset keeps every strobe low while reset is asserted.
  assign w_accept     = (r_state == S_IDLE) && in_valid && reset;
  assign in_ready     = (r_state == S_IDLE);
  assign busy         = (r_state != S_IDLE);
  assign mem_x_enable = w_accept;
  assign mem_x        = reset ? in_data : 32'd0;
  assign out_valid    = (r_state == S_HOLD);
  assign out_data     = r_out_data;

  always_comb begin
    mem_dir = 3'd0;
    if (r_state == S_ISSUE)      mem_dir = r_tap;
    else if (r_state == S_DRAIN) mem_dir = 3'd4;
  end

  // Tap data lags mem_dir by one cycle, so the MAC works on the previous tap.
  assign w_mac_en  = ((r_state == S_ISSUE) && (r_tap != 3'd0)) || (r_state == S_DRAIN);
  assign w_mac_sel = (r_state == S_DRAIN) ? 3'd4 : 3'(r_tap - 3'd1);

  always_comb begin
    w_coef = r_b0;
    w_sub  = 1'b0;
    case (w_mac_sel)
      3'd0:    w_coef = r_b0;
      3'd1:    w_coef = r_b1;
      3'd2:    w_coef = r_b2;
      3'd3:    begin w_coef = r_a1; w_sub = 1'b1; end
      default: begin w_coef = r_a2; w_sub = 1'b1; end
    endcase
  end

  assign w_prod     = mem_out * w_coef;
  assign w_prod_ext = {{(ACC_W - PROD_W){w_prod[PROD_W-1]}}, w_prod};

  // Round half toward +inf, then clip to the 32-bit sample range.
  assign w_round = r_acc + RND;
  assign w_shift = w_round >>> FRAC_BITS;

  always_comb begin
    w_y = w_shift[31:0];
    if (w_shift > SAT_HI)      w_y = 32'sh7FFF_FFFF;
    else if (w_shift < SAT_LO) w_y = 32'sh8000_0000;
  end

  assign mem_y_enable = (r_state == S_WRITE);
  assign mem_y        = (r_state == S_WRITE) ? w_y : 32'd0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_tap      <= 3'd0;
      r_acc      <= '0;
      r_b0       <= '0;
      r_b1       <= '0;
      r_b2       <= '0;
      r_a1       <= '0;
      r_a2       <= '0;
      r_out_data <= '0;
    end else begin
      if (w_mac_en)
        r_acc <= w_sub ? (r_acc - w_prod_ext) : (r_acc + w_prod_ext);
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_b0    <= coef_b0;
            r_b1    <= coef_b1;
            r_b2    <= coef_b2;
            r_a1    <= coef_a1;
            r_a2    <= coef_a2;
            r_acc   <= '0;
            r_tap   <= 3'd0;
            r_state <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (r_tap == 3'd4) r_state <= S_DRAIN;
          else               r_tap   <= r_tap + 3'd1;
        end
        S_DRAIN: r_state <= S_WRITE;
        S_WRITE: begin
          r_out_data <= w_y;
          r_state    <= S_HOLD;
        end
        S_HOLD:  if (out_ready) r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef BIQUAD_TAP_SEQUENCER_SAT_FLAG_EN
  logic r_out_sat;
  logic w_sat;

  assign w_sat   = (w_shift > SAT_HI) || (w_shift < SAT_LO);
  assign out_sat = r_out_sat;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                 r_out_sat <= 1'b0;
    else if (r_state == S_WRITE) r_out_sat <= w_sat;
  end
`endif

endmodule

// File: tb/tb_biquad_tap_sequencer.sv
module tb_biquad_tap_sequencer;

  logic               clk = 1'b0;
  logic               reset = 1'b0;
  logic               in_valid = 1'b0;
  logic               in_ready;
  logic signed [31:0] in_data = '0;
  logic signed [17:0] coef_b0 = '0, coef_b1 = '0, coef_b2 = '0, coef_a1 = '0, coef_a2 = '0;
  logic               mem_x_enable;
  logic [31:0]        mem_x;
  logic               mem_y_enable;
  logic [31:0]        mem_y;
  logic [2:0]         mem_dir;
  logic signed [31:0] mem_out;
  logic               out_valid;
  logic               out_ready = 1'b1;
  logic signed [31:0] out_data;
  logic               busy;
`ifdef BIQUAD_TAP_SEQUENCER_SAT_FLAG_EN
  logic               out_sat;
`endif

  int total = 0;
  int bad   = 0;

  biquad_tap_sequencer dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .coef_b0(coef_b0), .coef_b1(coef_b1), .coef_b2(coef_b2),
    .coef_a1(coef_a1), .coef_a2(coef_a2),
    .mem_x_enable(mem_x_enable), .mem_x(mem_x),
    .mem_y_enable(mem_y_enable), .mem_y(mem_y),
    .mem_dir(mem_dir), .mem_out(mem_out),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .busy(busy)
`ifdef BIQUAD_TAP_SEQUENCER_SAT_FLAG_EN
    , .out_sat(out_sat)
`endif
  );

  always #5 clk = ~clk;

  // Tap memory: two 2-deep delay lines plus a registered read port.
  logic signed [31:0] x0, x1, x2, y1, y2;
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      x0 <= 0; x1 <= 0; x2 <= 0; y1 <= 0; y2 <= 0; mem_out <= 0;
    end else begin
      if (mem_x_enable) begin x0 <= mem_x; x1 <= x0; x2 <= x1; end
      if (mem_y_enable) begin y1 <= mem_y; y2 <= y1; end
      case (mem_dir)
        3'd0: mem_out <= x0;
        3'd1: mem_out <= x1;
        3'd2: mem_out <= x2;
        3'd3: mem_out <= y1;
        3'd4: mem_out <= y2;
        default: mem_out <= 32'hDEAD_BEEF;
      endcase
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_coef(input int b0, input int b1, input int b2, input int a1, input int a2);
    coef_b0 = 18'(b0); coef_b1 = 18'(b1); coef_b2 = 18'(b2);
    coef_a1 = 18'(a1); coef_a2 = 18'(a2);
  endtask

  // Called #1 after a posedge with the DUT idle; returns #1 after the
  // posedge where the DUT is idle again. hold = HOLD cycles with out_ready=0.
  task automatic run(input string tag, input logic [31:0] x, input logic [31:0] exp,
                     input logic exp_sat, input int hold);
    int ye, xe;
    logic signed [17:0] s0, s1, s2, s3, s4;
    chk({tag, ".in_ready0"}, 32'(in_ready), 1);
    in_valid = 1'b1; in_data = x; out_ready = (hold == 0);
    #1;
    chk({tag, ".x_en"}, 32'(mem_x_enable), 1);
    chk({tag, ".mem_x"}, mem_x, x);
    @(posedge clk); #1;
    in_valid = 1'b0; in_data = 0;
    // coefficient changes after accept must be ignored
    s0 = coef_b0; s1 = coef_b1; s2 = coef_b2; s3 = coef_a1; s4 = coef_a2;
    set_coef(777, -555, 1234, 4321, -999);
    xe = 0; ye = 0;
    for (int c = 1; c <= 7; c++) begin
      if (c > 1) begin @(posedge clk); #1; end
      xe += int'(mem_x_enable); ye += int'(mem_y_enable);
      if (c == 7) begin
        chk({tag, ".y_en7"}, 32'(mem_y_enable), 1);
        chk({tag, ".mem_y"}, mem_y, exp);
      end
    end
    chk({tag, ".y_en_count"}, 32'(ye), 1);
    chk({tag, ".x_en_count"}, 32'(xe), 0);
    @(posedge clk); #1;
    chk({tag, ".out_valid8"}, 32'(out_valid), 1);
    chk({tag, ".out_data"}, out_data, exp);
    chk({tag, ".in_ready_hold"}, 32'(in_ready), 0);
`ifdef BIQUAD_TAP_SEQUENCER_SAT_FLAG_EN
    chk({tag, ".out_sat"}, 32'(out_sat), 32'(exp_sat));
`else
    if (exp_sat === 1'bx) $display("note: %s", tag);
`endif
    ye = 0;
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      ye += int'(mem_y_enable);
      chk({tag, ".bp_valid"}, 32'(out_valid), 1);
      chk({tag, ".bp_data"}, out_data, exp);
      chk({tag, ".bp_in_ready"}, 32'(in_ready), 0);
    end
    if (hold > 0) chk({tag, ".bp_y_en"}, 32'(ye), 0);
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk({tag, ".in_ready_after"}, 32'(in_ready), 1);
    chk({tag, ".out_valid_after"}, 32'(out_valid), 0);
    set_coef(s0, s1, s2, s3, s4);
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, ".in_ready"}, 32'(in_ready), 1);
    chk({tag, ".busy"}, 32'(busy), 0);
    chk({tag, ".x_en"}, 32'(mem_x_enable), 0);
    chk({tag, ".y_en"}, 32'(mem_y_enable), 0);
    chk({tag, ".mem_y"}, mem_y, 0);
    chk({tag, ".mem_dir"}, 32'(mem_dir), 0);
    chk({tag, ".out_valid"}, 32'(out_valid), 0);
    chk({tag, ".out_data"}, out_data, 0);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    #1;
    chk_reset_outs("rst");
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;

    // passthrough
    set_coef(16384, 0, 0, 0, 0);
    run("pass", 1000, 1000, 1'b0, 0);

    // pure one-sample delay
    do_reset();
    set_coef(0, 16384, 0, 0, 0);
    run("dly0", 5, 0, 1'b0, 0);
    run("dly1", 7, 5, 1'b0, 0);

    // y = x + 0.5*y1
    do_reset();
    set_coef(16384, 0, 0, -8192, 0);
    run("fb0", 1000, 1000, 1'b0, 0);
    run("fb1", 0, 500, 1'b0, 0);
    run("fb2", 0, 250, 1'b0, 0);

    // rounding and saturation
    do_reset();
    set_coef(8192, 0, 0, 0, 0);
    run("rnd_p", 3, 2, 1'b0, 0);
    run("rnd_n", 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 0);
    set_coef(65536, 0, 0, 0, 0);
    run("sat_hi", 32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b1, 0);
    run("sat_lo", 32'h8000_0000, 32'h8000_0000, 1'b1, 0);

    // backpressure, then next sample right after out_ready rises
    do_reset();
    set_coef(16384, 0, 0, 0, 0);
    run("bp", 123, 123, 1'b0, 10);
    run("bp_next", 456, 456, 1'b0, 0);

    // reset in the third ISSUE cycle
    set_coef(16384, 16384, 0, 0, 0);
    in_valid = 1'b1; in_data = 500;
    @(posedge clk); #1; in_valid = 1'b0; in_data = 0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("mid.mem_dir", 32'(mem_dir), 2);
    chk("mid.busy", 32'(busy), 1);
    reset = 1'b0;
    #1;
    chk_reset_outs("mid_rst");
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("mid.no_y_en", 32'(mem_y_enable), 0);
    end
    reset = 1'b1;
    @(posedge clk); #1;
    run("post_rst", 77, 77, 1'b0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/biquad_tap_sequencer.md
Name: biquad_tap_sequencer

Overview:
- Read-side controller and MAC for the 5-entry filter tap memory.
- On each accepted input sample it does three things:
  - pushes the sample into the x delay line;
  - reads the five taps in sequence and computes y[n] = b0·x[n] + b1·x[n-1] + b2·x[n-2] − a1·y[n-1] − a2·y[n-2];
  - writes y[n] back into the y delay line and presents it downstream with a valid/ready handshake.
- Sits between the sample source and the tap memory; one instance per biquad section.

Parameters:
- COEF_W, 18: signed coefficient width.
- FRAC_BITS, 14: fractional bits of the coefficients. 1.0 = 2^FRAC_BITS.
- ACC_W, COEF_W+35: signed accumulator width.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- in_valid  in  1  input sample valid.
- in_ready  out  1  block can accept a sample.
- in_data  in  32  signed input sample x[n].
- coef_b0, coef_b1, coef_b2, coef_a1, coef_a2  in  COEF_W each  signed coefficients. Sampled when a sample is accepted.
- mem_x_enable  out  1  shift strobe for the x delay line.
- mem_x  out  32  data for the x delay line (= in_data).
- mem_y_enable  out  1  shift strobe for the y delay line.
- mem_y  out  32  data for the y delay line (= y[n]).
- mem_dir  out  3  tap select: 0=x[n], 1=x[n-1], 2=x[n-2], 3=y[n-1], 4=y[n-2].
- mem_out  in  32  signed tap data. Registered in the memory: valid 1 cycle after mem_dir.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts result.
- out_data  out  32  signed y[n].
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (reset=0, asynchronous):
  - Outputs: in_ready=1, all other outputs 0.
  - Internal: state=IDLE, accumulator=0, latched coefficients=0.
  - Asserting reset mid-operation aborts the computation. No partial write to mem_y occurs after reset asserts.
  - The tap memory's own (active-high) reset is driven from !reset at integration.
- States and transitions:
  - IDLE → ISSUE, on accept.
  - ISSUE, 5 cycles → DRAIN.
  - DRAIN, 1 cycle → WRITE.
  - WRITE, 1 cycle → HOLD.
  - HOLD → IDLE, when out_ready=1.
- IDLE:
  - in_ready=1.
  - Accept = in_valid & in_ready.
  - On accept: mem_x_enable=1 and mem_x=in_data in the same cycle, combinationally. Coefficients are latched and the accumulator is cleared.
- ISSUE:
  - mem_dir = 0,1,2,3,4 on consecutive cycles.
  - From the 2nd ISSUE cycle, each cycle adds the tap returned for the previous mem_dir times its coefficient to the accumulator: b0/b1/b2 are added, a1/a2 are subtracted.
- DRAIN:
  - Accumulates the tap-4 product.
  - mem_dir holds 4.
- WRITE:
  - Computes y = sat32((acc + 2^(FRAC_BITS−1)) >>> FRAC_BITS), using an arithmetic shift (round half toward +inf).
  - Saturation bounds: −2^31 and 2^31−1.
  - mem_y_enable=1 for exactly this cycle, with mem_y=y.
  - out_data is registered with y.
- HOLD:
  - out_valid=1 and out_data stable until out_ready=1.
  - in_ready=0; no new sample is accepted.
  - The result is already in memory, so backpressure never repeats y_enable.
- Latency: a sample accepted in cycle 0 gives out_valid=1 in cycle 8.
- Throughput: one sample per 9 cycles when out_ready is held high. If out_ready=1 on the first HOLD cycle, in_ready rises in the next cycle.
- Width rules:
  - Products are 32+COEF_W bits, sign-extended to ACC_W.
  - The accumulator cannot overflow with the default ACC_W.
- Coefficient changes outside IDLE have no effect until the next accept.
- mem_x_enable and mem_y_enable are never high in the same cycle, and each is never high for more than one cycle per sample.

Optional Feature:
- Macro: BIQUAD_TAP_SEQUENCER_SAT_FLAG_EN.
- Defined:
  - Adds output out_sat (1 bit), registered in WRITE alongside out_data and valid while out_valid=1.
  - out_sat=1 iff clipping occurred; reset value 0.
- Undefined:
  - The port does not exist.
  - Saturation behaviour is unchanged.

Test Plan:
- Passthrough: b0=16384, other coefficients 0, input 1000 → out_data=1000 with out_valid in cycle 8; mem_x_enable in cycle 0 and mem_y_enable in cycle 7, one cycle each.
- Delay: b1=16384 only, inputs 5 then 7 → outputs 0 then 5.
- Feedback: b0=16384, a1=−8192 (y = x + 0.5·y1), inputs 1000, 0, 0 → outputs 1000, 500, 250.
- Rounding and saturation:
  - b0=8192, x=3 → 2; x=−3 → −1.
  - b0=65536, x=0x7FFFFFFF → 0x7FFFFFFF, out_sat=1.
  - b0=65536, x=0x80000000 → 0x80000000, out_sat=1.
- Backpressure: out_ready=0 for 10 cycles → out_data stable, in_ready=0, mem_y_enable pulsed once; the next sample is accepted in the cycle after out_ready rises.
- Reset mid-ISSUE: assert reset at ISSUE cycle 3 → all outputs 0 asynchronously; no mem_y_enable; after release, in_ready=1 and a fresh sample computes correctly from zeroed taps.
